cpu1_soc: RTL and testbench
===========================

Name: cpu1_soc

Overview:
- Minimal 8-bit accumulator SoC: CPU core, 256-word RAM and a fixed-content boot ROM on one shared address/data bus.
- After reset, the core copies a program from ROM into RAM (boot phase), then fetches and executes it from RAM.
- Bus signals are exported so a bench can trace every transfer.
- Top-level block of the basic CPU design.

Parameters:
- ADDR_SIZE, 8, address bus width; RAM depth is 2**ADDR_SIZE words.
- WORD_SIZE, 8, data and instruction word width.
- PROG_LEN, 32, number of ROM words copied to RAM addresses 0..PROG_LEN-1 during boot.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- addr_bus  output  ADDR_SIZE  current bus address.
- data_bus  output  WORD_SIZE  current bus data: ROM/RAM read data, or write data when wr_en=1.
- wr_en  output  1  RAM write strobe for this cycle.
- boot  output  1  high while the ROM-to-RAM copy is in progress.
- halted  output  1  high after an HLT instruction executes.
- acc  output  WORD_SIZE  accumulator value.

Behaviour:
- Reset and bus rules:
  - One clock; reset is synchronous and active-high.
  - When rst is sampled high: state=BOOT_RD, boot counter=0, PC=0, ACC=0, IR=0, halted=0, and all RAM words cleared to 0.
  - A reset in any state, including mid-boot or mid-execution, restarts the full sequence.
  - Bus outputs are combinational from state. wr_en=0 in every state except BOOT_WR and the STA execute cycle.
- RAM:
  - Asynchronous read: data = RAM[addr_bus].
  - Synchronous write: RAM[addr_bus] <= data_bus at the rising edge when wr_en=1.
- ROM:
  - Combinational; drives the bus only while boot=1 and wr_en=0.
  - Unlisted words read 0.
- Boot states (boot=1):
  - BOOT_RD: addr_bus=cnt, data_bus=ROM[cnt]; the word is latched.
  - BOOT_WR: addr_bus=cnt, data_bus=latched word, wr_en=1. Then cnt++.
  - After writing cnt=PROG_LEN-1, go to FETCH. boot falls in that same cycle.
  - Boot takes 2*PROG_LEN cycles.
- Execute states (boot=0):
  - FETCH: addr_bus=PC, data_bus=RAM[PC]; IR <= data; PC <= PC+1 (wraps modulo 2**ADDR_SIZE).
  - EXEC: addr_bus = operand IR[4:0], zero-extended. Then return to FETCH.
  - Each instruction takes 2 cycles.
- ISA: opcode=IR[7:5], operand=IR[4:0].
  - 000 NOP.
  - 001 LDA: ACC <= RAM[op].
  - 010 ADD: ACC <= ACC+RAM[op].
  - 011 SUB: ACC <= ACC-RAM[op].
  - 100 AND: ACC <= ACC&RAM[op].
  - 101 STA: data_bus=ACC, wr_en=1.
  - 110 JMP: PC <= op.
  - 111 HLT: enter HALT.
- Arithmetic is modulo 2**WORD_SIZE; no carry or flags kept.
- HALT state: addr_bus=PC, wr_en=0, halted=1. Only rst leaves HALT.
- ROM contents; all other words 0:
  - Address 0: 0x30 (LDA 16).
  - Address 1: 0x51 (ADD 17).
  - Address 2: 0xB2 (STA 18).
  - Address 3: 0x73 (SUB 19).
  - Address 4: 0xB4 (STA 20).
  - Address 5: 0xE0 (HLT).
  - Address 16: 0x05.
  - Address 17: 0x03.
  - Address 19: 0x02.

Optional Feature:
- Macro: CPU1_ZERO_JUMP_EN.
- Defined: opcode 000 is JZ. In EXEC, PC <= operand if ACC==0, otherwise PC is unchanged.
- Undefined: opcode 000 is NOP.
- Both variants take 2 cycles and never write RAM.

Test Plan:
- Reset held 3 cycles then released -> boot=1, cycle 0 shows addr 0, data 0x30, wr_en 0; next cycle addr 0, data 0x30, wr_en 1; boot=0 after 64 cycles.
- Run to completion -> write cycles at addr 18 data 0x08 and at addr 20 data 0x06; halted=1; acc=0x06; first HALT cycle addr_bus=6.
- Reset asserted at boot cycle 25, released, run 200 cycles -> boot restarts at addr 0, same final result (acc=0x06, halted=1), no extra RAM writes beyond boot/STA.
- Reset asserted while halted -> halted=0, acc=0, boot=1 next cycle; program re-executes identically.
- Bench force-loads ROM word 5 = 0xC0 (JMP 0) -> program loops; addr 18 written 0x08 each pass, halted stays 0.
- With CPU1_ZERO_JUMP_EN, ROM word 5 = 0x07 (JZ 7), ACC=6 -> falls through to word 6 (0x00 is JZ 0, not taken) and so on; with ACC forced 0 via LDA of a zero word -> PC jumps to 7.

Source files
------------

// File: rtl/cpu1_soc.sv
// 8-bit accumulator SoC: core, 256-word RAM and a boot ROM on one shared bus.
// Optional feature macro CPU1_ZERO_JUMP_EN turns opcode 000 from NOP into JZ.
module cpu1_soc #(
    parameter int                    ADDR_SIZE      = 8,
    parameter int                    WORD_SIZE      = 8,
    parameter int                    PROG_LEN       = 32,
    parameter bit                    ROM_PATCH_EN   = 1'b0,
    parameter logic [ADDR_SIZE-1:0]  ROM_PATCH_ADDR = {ADDR_SIZE{1'b0}},
    parameter logic [WORD_SIZE-1:0]  ROM_PATCH_DATA = {WORD_SIZE{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_SIZE-1:0] addr_bus,
    output logic [WORD_SIZE-1:0] data_bus,
    output logic                 wr_en,
    output logic                 boot,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] acc
);

    localparam int                   RAM_DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] ONE_A     = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] LAST_A    = ADDR_SIZE'(PROG_LEN - 1);
    localparam logic [WORD_SIZE-1:0] ZERO_W    = {WORD_SIZE{1'b0}};

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_BOOT_RD = 3'd0,
        S_BOOT_WR = 3'd1,
        S_FETCH   = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   acc_q, acc_d;
    logic [WORD_SIZE-1:0]   ir_q, ir_d;
    logic [WORD_SIZE-1:0]   latch_q, latch_d;
    logic                   boot_q, boot_d;
    logic                   halted_q, halted_d;
    logic [WORD_SIZE-1:0]   ram_q [RAM_DEPTH];

    logic [ADDR_SIZE-1:0]   addr_s;
    logic [WORD_SIZE-1:0]   data_s;
    logic [WORD_SIZE-1:0]   ram_rd_s;
    logic                   wr_en_s;
    logic [2:0]             opcode_s;
    logic [ADDR_SIZE-1:0]   operand_s;

    function automatic logic [WORD_SIZE-1:0] rom_word(input logic [ADDR_SIZE-1:0] a);
        logic [WORD_SIZE-1:0] w;
        case (a)
            ADDR_SIZE'(0):  w = WORD_SIZE'(8'h30);
            ADDR_SIZE'(1):  w = WORD_SIZE'(8'h51);
            ADDR_SIZE'(2):  w = WORD_SIZE'(8'hB2);
            ADDR_SIZE'(3):  w = WORD_SIZE'(8'h73);
            ADDR_SIZE'(4):  w = WORD_SIZE'(8'hB4);
            ADDR_SIZE'(5):  w = WORD_SIZE'(8'hE0);
            ADDR_SIZE'(16): w = WORD_SIZE'(8'h05);
            ADDR_SIZE'(17): w = WORD_SIZE'(8'h03);
            ADDR_SIZE'(19): w = WORD_SIZE'(8'h02);
            default:        w = ZERO_W;
        endcase
        if (ROM_PATCH_EN && (a == ROM_PATCH_ADDR)) begin
            w = ROM_PATCH_DATA;
        end else begin
            w = w;
        end
        return w;
    endfunction

    assign opcode_s  = ir_q[7:5];
    assign operand_s = ADDR_SIZE'(ir_q[4:0]);
    assign ram_rd_s  = ram_q[addr_s];

    // Bus address and write strobe are pure functions of the current state.
    always_comb begin
        addr_s  = pc_q;
        wr_en_s = 1'b0;
        case (state_q)
            S_BOOT_RD: addr_s = cnt_q;
            S_BOOT_WR: begin
                addr_s  = cnt_q;
                wr_en_s = 1'b1;
            end
            S_FETCH:   addr_s = pc_q;
            S_EXEC: begin
                addr_s  = operand_s;
                wr_en_s = (opcode_s == OP_STA);
            end
            S_HALT:    addr_s = pc_q;
            default:   addr_s = pc_q;
        endcase
    end

    // Bus data source: ROM while copying, latched word on boot writes, ACC on STA, else RAM.
    always_comb begin
        data_s = ram_rd_s;
        case (state_q)
            S_BOOT_RD: data_s = rom_word(cnt_q);
            S_BOOT_WR: data_s = latch_q;
            S_EXEC: begin
                if (opcode_s == OP_STA) begin
                    data_s = acc_q;
                end else begin
                    data_s = ram_rd_s;
                end
            end
            default:   data_s = ram_rd_s;
        endcase
    end

    // Next-state and datapath updates for boot copy and fetch/execute.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        latch_d = latch_q;
        case (state_q)
            S_BOOT_RD: begin
                latch_d = data_s;
                state_d = S_BOOT_WR;
            end
            S_BOOT_WR: begin
                cnt_d = cnt_q + ONE_A;
                if (cnt_q == LAST_A) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_BOOT_RD;
                end
            end
            S_FETCH: begin
                ir_d    = data_s;
                pc_d    = pc_q + ONE_A;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_s)
                    OP_LDA: acc_d = data_s;
                    OP_ADD: acc_d = acc_q + data_s;
                    OP_SUB: acc_d = acc_q - data_s;
                    OP_AND: acc_d = acc_q & data_s;
                    OP_STA: acc_d = acc_q;
                    OP_JMP: pc_d  = operand_s;
                    OP_HLT: state_d = S_HALT;
`ifdef CPU1_ZERO_JUMP_EN
                    OP_NOP: begin
                        if (acc_q == ZERO_W) begin
                            pc_d = operand_s;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
`else
                    OP_NOP: acc_d = acc_q;
`endif
                    default: acc_d = acc_q;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT_RD;
        endcase
    end

    // boot/halted are registered from the next state so they flip on the same edge as the state.
    always_comb begin
        boot_d   = (state_d == S_BOOT_RD) || (state_d == S_BOOT_WR);
        halted_d = (state_d == S_HALT);
    end

    // Core state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_BOOT_RD;
            cnt_q    <= {ADDR_SIZE{1'b0}};
            pc_q     <= {ADDR_SIZE{1'b0}};
            acc_q    <= ZERO_W;
            ir_q     <= ZERO_W;
            latch_q  <= ZERO_W;
            boot_q   <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ir_q     <= ir_d;
            latch_q  <= latch_d;
            boot_q   <= boot_d;
            halted_q <= halted_d;
        end
    end

    // RAM: cleared by reset, written from the shared bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q <= '{default: ZERO_W};
        end else if (wr_en_s) begin
            ram_q[addr_s] <= data_s;
        end
    end

    assign addr_bus = addr_s;
    assign data_bus = data_s;
    assign wr_en    = wr_en_s;
    assign boot     = boot_q;
    assign halted   = halted_q;
    assign acc      = acc_q;

endmodule

// File: tb/tb_cpu1_soc.sv
// Bench for cpu1_soc: instruction-level trace model, vector table, directed reset sequences and random runs.
module tb_cpu1_soc;

`ifdef CPU1_ZERO_JUMP_EN
    localparam int NI = 4;
    localparam bit ZJ = 1'b1;
`else
    localparam int NI = 2;
    localparam bit ZJ = 1'b0;
`endif
    localparam int TLEN = 520;
    // Instance 0 plain ROM, 1: word5=JMP 0, 2: word5=JZ 7, 3: word0=JZ 7.
    localparam logic [3:0]  P_EN   = 4'b1110;
    localparam logic [31:0] P_ADDR = {8'd0, 8'd5, 8'd5, 8'd0};
    localparam logic [31:0] P_DATA = {8'h07, 8'h07, 8'hC0, 8'h00};

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       boot;
        logic       halted;
        logic [7:0] acc;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       boot;
        logic       halted;
        logic [7:0] acc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] addr_w   [NI];
    logic [7:0] data_w   [NI];
    logic [7:0] acc_w    [NI];
    logic       wr_w     [NI];
    logic       boot_w   [NI];
    logic       halted_w [NI];

    exp_t tr [NI][TLEN];
    vec_t vt [11];
    int   n_cmp;
    int   n_bad;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cpu1_soc #(
            .ADDR_SIZE(8), .WORD_SIZE(8), .PROG_LEN(32),
            .ROM_PATCH_EN(P_EN[g]),
            .ROM_PATCH_ADDR(P_ADDR[g*8 +: 8]),
            .ROM_PATCH_DATA(P_DATA[g*8 +: 8])
        ) u_dut (
            .clk(clk), .rst(rst),
            .addr_bus(addr_w[g]), .data_bus(data_w[g]), .wr_en(wr_w[g]),
            .boot(boot_w[g]), .halted(halted_w[g]), .acc(acc_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tb_rom(input logic [7:0] a, input int k);
        logic [7:0] w;
        case (a)
            8'd0: w = 8'h30;  8'd1: w = 8'h51;  8'd2: w = 8'hB2;
            8'd3: w = 8'h73;  8'd4: w = 8'hB4;  8'd5: w = 8'hE0;
            8'd16: w = 8'h05; 8'd17: w = 8'h03; 8'd19: w = 8'h02;
            default: w = 8'h00;
        endcase
        if (P_EN[k] && a == P_ADDR[k*8 +: 8]) w = P_DATA[k*8 +: 8];
        return w;
    endfunction

    // Instruction-level interpreter that emits the expected per-cycle bus trace.
    function automatic void build_trace(input int k);
        logic [7:0] mem [256];
        logic [7:0] pc, ac, ir, op;
        bit         hlt;
        int         n;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        n = 0;
        for (int a = 0; a < 32; a++) begin
            tr[k][n] = '{8'(a), tb_rom(8'(a), k), 1'b0, 1'b1, 1'b0, 8'h00}; n++;
            tr[k][n] = '{8'(a), tb_rom(8'(a), k), 1'b1, 1'b1, 1'b0, 8'h00}; n++;
            mem[a] = tb_rom(8'(a), k);
        end
        pc = 8'h00; ac = 8'h00; hlt = 1'b0;
        while (n < TLEN) begin
            if (hlt) begin
                tr[k][n] = '{pc, mem[pc], 1'b0, 1'b0, 1'b1, ac}; n++;
            end else begin
                ir = mem[pc];
                tr[k][n] = '{pc, ir, 1'b0, 1'b0, 1'b0, ac}; n++;
                pc = pc + 8'd1;
                op = {3'b000, ir[4:0]};
                if (n < TLEN) begin
                    if (ir[7:5] == 3'd5) tr[k][n] = '{op, ac, 1'b1, 1'b0, 1'b0, ac};
                    else                 tr[k][n] = '{op, mem[op], 1'b0, 1'b0, 1'b0, ac};
                    n++;
                end
                case (ir[7:5])
                    3'd1: ac = mem[op];
                    3'd2: ac = ac + mem[op];
                    3'd3: ac = ac - mem[op];
                    3'd4: ac = ac & mem[op];
                    3'd5: mem[op] = ac;
                    3'd6: pc = op;
                    3'd7: hlt = 1'b1;
                    default: if (ZJ && ac == 8'h00) pc = op;
                endcase
            end
        end
    endfunction

    task automatic chk(input string nm, input int k, input int c, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc%0d: got %02h expected %02h", nm, k, c, got, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        for (int k = 0; k < NI; k++) begin
            chk("addr",   k, c, addr_w[k],             tr[k][c].addr);
            chk("data",   k, c, data_w[k],             tr[k][c].data);
            chk("wr_en",  k, c, {7'd0, wr_w[k]},       {7'd0, tr[k][c].wr});
            chk("boot",   k, c, {7'd0, boot_w[k]},     {7'd0, tr[k][c].boot});
            chk("halted", k, c, {7'd0, halted_w[k]},   {7'd0, tr[k][c].halted});
            chk("acc",    k, c, acc_w[k],              tr[k][c].acc);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_check(input int len);
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            check_cycle(c);
        end
    endtask

    initial begin
        int wr_cnt;
        int exp_cnt;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) build_trace(k);

        vt[0]  = '{0,   8'd0,  8'h30, 1'b0, 1'b1, 1'b0, 8'h00};
        vt[1]  = '{1,   8'd0,  8'h30, 1'b1, 1'b1, 1'b0, 8'h00};
        vt[2]  = '{33,  8'd16, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00};
        vt[3]  = '{63,  8'd31, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vt[4]  = '{64,  8'd0,  8'h30, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{65,  8'd16, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{69,  8'd18, 8'h08, 1'b1, 1'b0, 1'b0, 8'h08};
        vt[7]  = '{73,  8'd20, 8'h06, 1'b1, 1'b0, 1'b0, 8'h06};
        vt[8]  = '{75,  8'd0,  8'h30, 1'b0, 1'b0, 1'b0, 8'h06};
        vt[9]  = '{76,  8'd6,  8'h00, 1'b0, 1'b0, 1'b1, 8'h06};
        vt[10] = '{150, 8'd6,  8'h00, 1'b0, 1'b0, 1'b1, 8'h06};

        // Vector table against the unpatched instance, each from a fresh 3-cycle reset.
        for (int i = 0; i < 11; i++) begin
            do_reset(3);
            repeat (vt[i].cyc) @(negedge clk);
            chk("vec_addr",   0, vt[i].cyc, addr_w[0],           vt[i].addr);
            chk("vec_data",   0, vt[i].cyc, data_w[0],           vt[i].data);
            chk("vec_wr",     0, vt[i].cyc, {7'd0, wr_w[0]},     {7'd0, vt[i].wr});
            chk("vec_boot",   0, vt[i].cyc, {7'd0, boot_w[0]},   {7'd0, vt[i].boot});
            chk("vec_halted", 0, vt[i].cyc, {7'd0, halted_w[0]}, {7'd0, vt[i].halted});
            chk("vec_acc",    0, vt[i].cyc, acc_w[0],            vt[i].acc);
        end

        // Reset in the middle of boot, then a full run with a write count.
        do_reset(3);
        run_check(26);
        do_reset(1);
        wr_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            check_cycle(c);
            if (wr_w[0]) wr_cnt++;
        end
        chk("write_count", 0, 200, 8'(wr_cnt), 8'd34);

        // Reset while halted: state clears on the next cycle and the program repeats.
        @(negedge clk);
        chk("pre_halted", 0, 0, {7'd0, halted_w[0]}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_halted", 0, 0, {7'd0, halted_w[0]}, 8'd0);
        chk("rst_acc",    0, 0, acc_w[0],            8'd0);
        chk("rst_boot",   0, 0, {7'd0, boot_w[0]},   8'd1);
        rst = 1'b0;
        run_check(100);

        // JMP-0 loop instance: addr 18 written with 0x08 on every pass and never halts.
        do_reset(2);
        wr_cnt = 0;
        exp_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            check_cycle(c);
            if (wr_w[1] && addr_w[1] == 8'd18 && data_w[1] == 8'h08) wr_cnt++;
            if (c >= 64 && ((c - 64) % 12) == 5) exp_cnt++;
        end
        chk("loop_sta18", 1, 400, 8'(wr_cnt), 8'(exp_cnt));
        chk("loop_halted", 1, 400, {7'd0, halted_w[1]}, 8'd0);

        // Random reset points and run lengths, every cycle against the model trace.
        for (int t = 0; t < 20; t++) begin
            do_reset(int'($urandom_range(1, 3)));
            run_check(int'($urandom_range(1, 300)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
